// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: serialises I-cache and D-cache line requests onto the
// single AXI line bridge, one outstanding transaction at a time.
// Ports: aclk/aresetn; I-cache (i_rd_req, i_addr, i_gnt, i_rd_line);
// D-cache (d_rd_req, d_wr_req, d_addr, d_wr_line, d_gnt, d_rd_line);
// bridge (m_rd_req, m_wr_req, m_addr, m_wr_line, m_gnt, m_rd_line).
// Option: define ARB_DCACHE_PRIORITY_EN for fixed D-cache priority on ties
// (default build is round robin).
module cache_axi_arbiter #(
    parameter  int LINE_ADDR_LEN = 3,
    localparam int LINE_WORDS    = 1 << LINE_ADDR_LEN
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        i_rd_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic [31:0] i_rd_line [LINE_WORDS],
    input  logic        d_rd_req,
    input  logic        d_wr_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wr_line [LINE_WORDS],
    output logic        d_gnt,
    output logic [31:0] d_rd_line [LINE_WORDS],
    output logic        m_rd_req,
    output logic        m_wr_req,
    output logic [31:0] m_addr,
    output logic [31:0] m_wr_line [LINE_WORDS],
    input  logic        m_gnt,
    input  logic [31:0] m_rd_line [LINE_WORDS]
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0] state;
    logic       d_req;
    logic       i_win;
    logic       d_win;

    assign d_req = d_rd_req | d_wr_req;

`ifdef ARB_DCACHE_PRIORITY_EN
    assign d_win = d_req;
    assign i_win = i_rd_req & ~d_req;
`else
    // last_d = 1 when the D-cache was the most recent client served
    logic last_d;

    assign i_win = i_rd_req & (~d_req | last_d);
    assign d_win = d_req & ~i_win;
`endif

    // Grants are only meaningful while the matching transaction is held
    assign i_gnt = (state == BUSY_I) & m_gnt;
    assign d_gnt = (state == BUSY_D) & m_gnt;

    assign i_rd_line = m_rd_line;
    assign d_rd_line = m_rd_line;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            m_rd_req  <= 1'b0;
            m_wr_req  <= 1'b0;
            m_addr    <= 32'h0;
            m_wr_line <= '{default: 32'h0};
`ifndef ARB_DCACHE_PRIORITY_EN
            last_d    <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_win) begin
                        state    <= BUSY_I;
                        m_addr   <= i_addr;
                        m_rd_req <= 1'b1;
                    end else if (d_win) begin
                        state     <= BUSY_D;
                        m_addr    <= d_addr;
                        m_wr_line <= d_wr_line;
                        // a simultaneous read+write is served as the write
                        m_wr_req  <= d_wr_req;
                        m_rd_req  <= ~d_wr_req;
                    end
                end
                BUSY_I: begin
                    if (m_gnt) begin
                        state    <= DONE;
                        m_rd_req <= 1'b0;
                        m_wr_req <= 1'b0;
`ifndef ARB_DCACHE_PRIORITY_EN
                        last_d   <= 1'b0;
`endif
                    end
                end
                BUSY_D: begin
                    if (m_gnt) begin
                        state    <= DONE;
                        m_rd_req <= 1'b0;
                        m_wr_req <= 1'b0;
`ifndef ARB_DCACHE_PRIORITY_EN
                        last_d   <= 1'b1;
`endif
                    end
                end
                // one dead cycle lets the served client drop its request
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter: directed table, hand sequences and a randomized
// run against a cycle-counting transaction model of the arbiter.
module tb_cache_axi_arbiter;

    localparam int LW = 8;
    typedef logic [31:0] line_t [LW];

    localparam logic [31:0] IA = 32'h0000_4440;
    localparam logic [31:0] DA = 32'h0000_D0C0;

`ifdef ARB_DCACHE_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        i_rd_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt;
    line_t       i_rd_line;
    logic        d_rd_req = 1'b0;
    logic        d_wr_req = 1'b0;
    logic [31:0] d_addr = '0;
    line_t       d_wr_line;
    logic        d_gnt;
    line_t       d_rd_line;
    logic        m_rd_req;
    logic        m_wr_req;
    logic [31:0] m_addr;
    line_t       m_wr_line;
    logic        m_gnt = 1'b0;
    line_t       m_rd_line;

    int vectors = 0;
    int miscompares = 0;

    cache_axi_arbiter #(.LINE_ADDR_LEN(3)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_rd_req(i_rd_req), .i_addr(i_addr),
        .i_gnt(i_gnt), .i_rd_line(i_rd_line),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req),
        .d_addr(d_addr), .d_wr_line(d_wr_line),
        .d_gnt(d_gnt), .d_rd_line(d_rd_line),
        .m_rd_req(m_rd_req), .m_wr_req(m_wr_req),
        .m_addr(m_addr), .m_wr_line(m_wr_line),
        .m_gnt(m_gnt), .m_rd_line(m_rd_line)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] line_diff(input line_t a, input line_t b);
        logic [31:0] n = 0;
        for (int k = 0; k < LW; k++) if (a[k] !== b[k]) n++;
        return n;
    endfunction

    task automatic quiet();
        i_rd_req = 0; d_rd_req = 0; d_wr_req = 0; m_gnt = 0;
    endtask

    task automatic do_reset();
        quiet();
        aresetn = 0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1;
    endtask

    // Called at a negedge while busy; returns at a negedge in IDLE.
    task automatic grant_and_drop();
        m_gnt = 1;
        @(negedge aclk);
        m_gnt = 0;
        i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
        @(negedge aclk);
    endtask

    typedef struct {
        bit prime_i;
        bit ir, dr, dw;
        bit exp_rd, exp_wr;
        int exp_sel;   // 0: reset addr, 1: I addr, 2: D addr
    } arb_vec_t;

    arb_vec_t tbl [9];
    line_t    zl;
    line_t    el;

    // model state for the random run
    bit          outst, own_d, last_d, exp_rd, exp_wr, take_d, i_got, d_got;
    bit          bact;
    int          bcnt, cyc_free;
    logic [31:0] exp_addr;
    line_t       exp_line;

    initial begin
        for (int k = 0; k < LW; k++) begin
            zl[k] = 0; d_wr_line[k] = 0; m_rd_line[k] = 0;
        end

        tbl[0] = '{0, 1, 0, 0, 1, 0, 1};
        tbl[1] = '{0, 0, 1, 0, 1, 0, 2};
        tbl[2] = '{0, 0, 0, 1, 0, 1, 2};
        tbl[3] = '{0, 0, 1, 1, 0, 1, 2};
        tbl[4] = PRIO ? '{0, 1, 1, 0, 1, 0, 2} : '{0, 1, 1, 0, 1, 0, 1};
        tbl[5] = '{1, 1, 1, 0, 1, 0, 2};
        tbl[6] = '{1, 1, 0, 1, 0, 1, 2};
        tbl[7] = PRIO ? '{0, 1, 0, 1, 0, 1, 2} : '{0, 1, 0, 1, 1, 0, 1};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 0};

        do_reset();
        #1;
        chk("rst_rd_req", m_rd_req, 0);
        chk("rst_wr_req", m_wr_req, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_line", line_diff(m_wr_line, zl), 0);

        // arbitration table
        for (int i = 0; i < 9; i++) begin
            do_reset();
            if (tbl[i].prime_i) begin
                i_rd_req = 1; i_addr = IA;
                @(negedge aclk);
                grant_and_drop();
            end
            i_addr = IA; d_addr = DA;
            i_rd_req = tbl[i].ir;
            d_rd_req = tbl[i].dr;
            d_wr_req = tbl[i].dw;
            @(negedge aclk);
            #1;
            chk($sformatf("tbl%0d_rd", i), m_rd_req, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_wr", i), m_wr_req, tbl[i].exp_wr);
            chk($sformatf("tbl%0d_addr", i), m_addr,
                tbl[i].exp_sel == 1 ? IA : tbl[i].exp_sel == 2 ? DA : 32'h0);
            if (tbl[i].exp_rd || tbl[i].exp_wr) grant_and_drop();
            else quiet();
        end

        // I-cache read, grant after 12 cycles
        do_reset();
        i_rd_req = 1; i_addr = 32'h1fc0_0000;
        for (int n = 1; n <= 12; n++) begin
            @(negedge aclk);
            if (n == 12) begin
                for (int k = 0; k < LW; k++) m_rd_line[k] = k;
                m_gnt = 1;
            end
            #1;
            chk("t1_rd_req", m_rd_req, 1);
            chk("t1_wr_req", m_wr_req, 0);
            chk("t1_addr", m_addr, 32'h1fc0_0000);
            chk("t1_ignt", i_gnt, n == 12);
            chk("t1_dgnt", d_gnt, 0);
        end
        chk("t1_line7", i_rd_line[7], 7);
        @(negedge aclk);
        m_gnt = 0; i_rd_req = 0;
        #1;
        chk("t1_req_clr", m_rd_req, 0);
        chk("t1_ignt_clr", i_gnt, 0);
        @(negedge aclk);

        // D-cache write; client changes its line while held
        do_reset();
        d_wr_req = 1; d_addr = 32'h8000_1000;
        for (int k = 0; k < LW; k++) begin
            d_wr_line[k] = 32'hA0 + k;
            el[k] = 32'hA0 + k;
        end
        for (int n = 1; n <= 6; n++) begin
            @(negedge aclk);
            if (n == 3)
                for (int k = 0; k < LW; k++) d_wr_line[k] = 32'hdead_0000 + k;
            if (n == 6) m_gnt = 1;
            #1;
            chk("t2_wr_req", m_wr_req, 1);
            chk("t2_rd_req", m_rd_req, 0);
            chk("t2_addr", m_addr, 32'h8000_1000);
            chk("t2_line", line_diff(m_wr_line, el), 0);
            chk("t2_dgnt", d_gnt, n == 6);
            chk("t2_ignt", i_gnt, 0);
        end
        @(negedge aclk);
        m_gnt = 0; d_wr_req = 0;
        #1;
        chk("t2_req_clr", m_wr_req, 0);
        @(negedge aclk);

        // both read, back-to-back spacing
        do_reset();
        i_rd_req = 1; i_addr = IA; d_rd_req = 1; d_addr = DA;
        @(negedge aclk);
        #1;
        chk("t3_first_addr", m_addr, PRIO ? DA : IA);
        chk("t3_first_rd", m_rd_req, 1);
        @(negedge aclk);
        m_gnt = 1;
        #1;
        chk("t3_igGnt", i_gnt, !PRIO);
        chk("t3_dgnt", d_gnt, PRIO);
        @(negedge aclk);
        m_gnt = 0;
        if (PRIO) d_rd_req = 0; else i_rd_req = 0;
        #1;
        chk("t3_done_req", m_rd_req, 0);
        @(negedge aclk);
        #1;
        chk("t3_idle_req", m_rd_req, 0);
        @(negedge aclk);
        #1;
        chk("t3_second_rd", m_rd_req, 1);
        chk("t3_second_addr", m_addr, PRIO ? IA : DA);
        grant_and_drop();

        // async reset in the middle of a D write
        do_reset();
        d_wr_req = 1; d_addr = DA;
        for (int k = 0; k < LW; k++) d_wr_line[k] = 32'h5500 + k;
        @(negedge aclk);
        @(negedge aclk);
        #1;
        chk("t5_busy", m_wr_req, 1);
        #1;
        aresetn = 0;
        #1;
        chk("t5_wr_req", m_wr_req, 0);
        chk("t5_rd_req", m_rd_req, 0);
        chk("t5_addr", m_addr, 0);
        chk("t5_line", line_diff(m_wr_line, zl), 0);
        @(negedge aclk);
        aresetn = 1; d_wr_req = 0; i_rd_req = 1; i_addr = IA;
        @(negedge aclk);
        #1;
        chk("t5_after_rd", m_rd_req, 1);
        chk("t5_after_addr", m_addr, IA);
        grant_and_drop();

        // stray m_gnt in IDLE
        do_reset();
        @(negedge aclk);
        m_gnt = 1;
        #1;
        chk("t6_igGnt", i_gnt, 0);
        chk("t6_dgnt", d_gnt, 0);
        @(negedge aclk);
        m_gnt = 0;
        #1;
        chk("t6_rd_req", m_rd_req, 0);
        chk("t6_wr_req", m_wr_req, 0);
        d_rd_req = 1; d_addr = DA;
        @(negedge aclk);
        #1;
        chk("t6_accept", m_rd_req, 1);
        grant_and_drop();

        // randomized run
        do_reset();
        for (int k = 0; k < LW; k++) exp_line[k] = 0;
        outst = 0; last_d = 1; cyc_free = 0; bact = 0; bcnt = 0;
        i_got = 0; d_got = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge aclk);
            if (i_rd_req) begin
                if (i_got || $urandom_range(0, 40) == 0) i_rd_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                i_rd_req = 1; i_addr = $urandom;
            end
            if (d_rd_req || d_wr_req) begin
                if (d_got || $urandom_range(0, 40) == 0) begin
                    d_rd_req = 0; d_wr_req = 0;
                end else if ($urandom_range(0, 3) == 0) begin
                    for (int k = 0; k < LW; k++) d_wr_line[k] = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                int kind = $urandom_range(0, 2);
                d_rd_req = (kind != 1);
                d_wr_req = (kind != 0);
                d_addr = $urandom;
                for (int k = 0; k < LW; k++) d_wr_line[k] = $urandom;
            end
            for (int k = 0; k < LW; k++) m_rd_line[k] = $urandom;
            if (m_rd_req || m_wr_req) begin
                if (!bact) begin
                    bact = 1; bcnt = $urandom_range(0, 4);
                end
                m_gnt = (bcnt == 0);
                if (bcnt == 0) bact = 0; else bcnt--;
            end else begin
                bact = 0;
                m_gnt = ($urandom_range(0, 7) == 0);
            end
            #1;
            chk("r_rd_req", m_rd_req, outst && exp_rd);
            chk("r_wr_req", m_wr_req, outst && exp_wr);
            if (outst) chk("r_addr", m_addr, exp_addr);
            if (outst && own_d) chk("r_line", line_diff(m_wr_line, exp_line), 0);
            chk("r_igGnt", i_gnt, outst && m_gnt && !own_d);
            chk("r_dgnt", d_gnt, outst && m_gnt && own_d);
            if (outst && m_gnt) begin
                chk("r_rdline", line_diff(own_d ? d_rd_line : i_rd_line,
                                          m_rd_line), 0);
            end
            i_got = i_gnt;
            d_got = d_gnt;
            if (outst && m_gnt) begin
                outst = 0;
                last_d = own_d;
                cyc_free = c + 2;
            end else if (!outst && c >= cyc_free &&
                         (i_rd_req || d_rd_req || d_wr_req)) begin
                if (PRIO) take_d = d_rd_req || d_wr_req;
                else take_d = (d_rd_req || d_wr_req) && (!i_rd_req || !last_d);
                outst = 1;
                own_d = take_d;
                exp_addr = take_d ? d_addr : i_addr;
                exp_wr = take_d && d_wr_req;
                exp_rd = !exp_wr;
                if (take_d) exp_line = d_wr_line;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
